apb_master_fsm: RTL and testbench

Single-clock APB4 requester that sits on the APB side of the AXI-to-APB bridge, behind the command FIFO. It pops one packed command per transfer from the FIFO read port, runs the APB SETUP/ACCESS sequence and pushes one packed response into the response FIFO write port. A programmable timeout ends transfers whose `pready` never arrives. A saturating counter records error responses.

---
 rtl/apb_master_fsm.sv | 178 +++++++++++++++++
 tb/tb_apb_master_fsm.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_fsm.sv
// ----------------------------------------------------------------------------
// apb_master_fsm
//
// APB4 requester for the APB side of the AXI-to-APB bridge. It pops one packed
// command from the command FIFO, runs the APB SETUP/ACCESS sequence and pushes
// one packed response into the response FIFO. A programmable ACCESS-cycle
// timeout ends transfers whose pready never arrives. A saturating counter
// tracks responses that carry slverr.
//
// Ports
//   dst_clk, dst_rst          clock, asynchronous active-high reset
//   cmd_vld/cmd_rdy/cmd_data  command FIFO read port, {write, addr, wdata, strb}
//   rsp_vld/rsp_rdy/rsp_data  response FIFO write port, {timeout, slverr, rdata}
//   psel, penable, pwrite,    APB requester outputs (all registered)
//   paddr, pwdata, pstrb
//   pready, pslverr, prdata   APB completer inputs
//   busy                      high whenever the FSM is not in IDLE
//   err_cnt                   saturating count of responses with slverr=1
// ----------------------------------------------------------------------------
module apb_master_fsm #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256,
    parameter int CMD_WIDTH  = 1 + ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH/8
) (
    input  logic                    dst_clk,
    input  logic                    dst_rst,
    input  logic                    cmd_vld,
    output logic                    cmd_rdy,
    input  logic [CMD_WIDTH-1:0]    cmd_data,
    output logic                    rsp_vld,
    input  logic                    rsp_rdy,
    output logic [DATA_WIDTH+1:0]   rsp_data,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic                    pslverr,
    input  logic [DATA_WIDTH-1:0]   prdata,
    output logic                    busy,
    output logic [15:0]             err_cnt
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen during ACCESS cycle number TIMEOUT (cycles count from 1).
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_rsp_vld;
    logic                    r_busy;
    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic [STRB_W-1:0]       r_pstrb;
    logic [DATA_WIDTH+1:0]   r_rsp_data;
    logic [15:0]             r_err_cnt;

    // Command word fields, MSB to LSB: {write, addr, wdata, strb}.
    logic                    w_cmd_write;
    logic [ADDR_WIDTH-1:0]   w_cmd_addr;
    logic [DATA_WIDTH-1:0]   w_cmd_wdata;
    logic [STRB_W-1:0]       w_cmd_strb;
    logic                    w_accept;
    logic                    w_timeout_hit;
    logic                    w_done;
    logic                    w_slverr_nxt;

    assign w_cmd_write = cmd_data[CMD_WIDTH-1];
    assign w_cmd_addr  = cmd_data[CMD_WIDTH-2 -: ADDR_WIDTH];
    assign w_cmd_wdata = cmd_data[STRB_W +: DATA_WIDTH];
    assign w_cmd_strb  = cmd_data[STRB_W-1:0];

    // The pop strobe is held low while reset is asserted so the FIFO never
    // loses an entry to a command the FSM is about to forget.
    assign cmd_rdy  = (r_state == S_IDLE) && !dst_rst;
    assign w_accept = cmd_vld && cmd_rdy;

    // pready has priority: a timeout only counts when pready is low.
    assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
    assign w_done        = (r_state == S_ACCESS) && (pready || w_timeout_hit);
    assign w_slverr_nxt  = pready ? pslverr : 1'b1;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (w_done) w_next = S_RESP;
            S_RESP:   if (rsp_rdy) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Control flops are decoded from the next state so the registered outputs
    // line up with the state they describe.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge dst_clk or posedge dst_rst) begin
        if (dst_rst) begin
            r_state   <= S_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rsp_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next;
            r_psel    <= (w_next == S_SETUP) || (w_next == S_ACCESS);
            r_penable <= (w_next == S_ACCESS);
            r_rsp_vld <= (w_next == S_RESP);
            r_busy    <= (w_next != S_IDLE);
            if (r_state == S_SETUP) begin
                r_cnt <= '0;
            end else if ((r_state == S_ACCESS) && !w_done) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Address/data phase registers change only on command acceptance and hold
    // their last value between transfers.
    always_ff @(posedge dst_clk or posedge dst_rst) begin
        if (dst_rst) begin
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_pstrb    <= '0;
            r_rsp_data <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_pwrite <= w_cmd_write;
                r_paddr  <= w_cmd_addr;
                r_pwdata <= w_cmd_wdata;
                r_pstrb  <= w_cmd_write ? w_cmd_strb : '0;
            end
            if (w_done) begin
                if (pready) begin
                    r_rsp_data <= {1'b0, pslverr, (r_pwrite ? {DATA_WIDTH{1'b0}} : prdata)};
                end else begin
                    r_rsp_data <= {1'b1, 1'b1, {DATA_WIDTH{1'b0}}};
                end
                if (w_slverr_nxt && (r_err_cnt != 16'hFFFF)) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
        end
    end

    assign psel     = r_psel;
    assign penable  = r_penable;
    assign pwrite   = r_pwrite;
    assign paddr    = r_paddr;
    assign pwdata   = r_pwdata;
    assign pstrb    = r_pstrb;
    assign rsp_vld  = r_rsp_vld;
    assign rsp_data = r_rsp_data;
    assign busy     = r_busy;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_apb_master_fsm.sv
// ----------------------------------------------------------------------------
// tb_apb_master_fsm
//
// Directed bench for apb_master_fsm with TIMEOUT=8: reset state, write, read
// with wait states, slverr counting, timeout and pready-on-last-cycle,
// response back-pressure with a queued command, and reset mid-ACCESS.
// ----------------------------------------------------------------------------
module tb_apb_master_fsm;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int CW    = 1 + AW + DW + SW;

    logic          dst_clk;
    logic          dst_rst;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic [CW-1:0] cmd_data;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW+1:0] rsp_data;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          pready;
    logic          pslverr;
    logic [DW-1:0] prdata;
    logic          busy;
    logic [15:0]   err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    apb_master_fsm #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (8)
    ) dut (
        .dst_clk  (dst_clk),
        .dst_rst  (dst_rst),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .cmd_data (cmd_data),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_data (rsp_data),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .pready   (pready),
        .pslverr  (pslverr),
        .prdata   (prdata),
        .busy     (busy),
        .err_cnt  (err_cnt)
    );

    initial dst_clk = 1'b0;
    always #5 dst_clk = ~dst_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge dst_clk);
        #1;
    endtask

    function automatic logic [CW-1:0] mk_cmd(input logic w, input logic [AW-1:0] a,
                                             input logic [DW-1:0] d, input logic [SW-1:0] s);
        return {w, a, d, s};
    endfunction

    // Present a command for one edge; the FSM must be in IDLE for it to be taken.
    task automatic send(input logic [CW-1:0] c);
        cmd_vld  = 1'b1;
        cmd_data = c;
        tick();
        cmd_vld  = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [DW+1:0] held;

        dst_rst  = 1'b1;
        cmd_vld  = 1'b0;
        cmd_data = '0;
        rsp_rdy  = 1'b1;
        pready   = 1'b0;
        pslverr  = 1'b0;
        prdata   = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_psel",    64'(psel),     64'h0);
        check("rst_penable", 64'(penable),  64'h0);
        check("rst_pwrite",  64'(pwrite),   64'h0);
        check("rst_paddr",   64'(paddr),    64'h0);
        check("rst_pwdata",  64'(pwdata),   64'h0);
        check("rst_pstrb",   64'(pstrb),    64'h0);
        check("rst_rsp_vld", 64'(rsp_vld),  64'h0);
        check("rst_rsp_data",64'(rsp_data), 64'h0);
        check("rst_busy",    64'(busy),     64'h0);
        check("rst_err_cnt", 64'(err_cnt),  64'h0);
        check("rst_cmd_rdy", 64'(cmd_rdy),  64'h0);
        dst_rst = 1'b0;
        #1;
        check("rel_cmd_rdy", 64'(cmd_rdy),  64'h1);

        // ---------------- write, zero wait states ----------------
        pready = 1'b1;
        send(mk_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF));
        check("wr_setup_psel",    64'(psel),    64'h1);
        check("wr_setup_penable", 64'(penable), 64'h0);
        check("wr_setup_cmd_rdy", 64'(cmd_rdy), 64'h0);
        check("wr_setup_busy",    64'(busy),    64'h1);
        check("wr_paddr",         64'(paddr),   64'h10);
        check("wr_pwdata",        64'(pwdata),  64'hDEADBEEF);
        tick();
        check("wr_access_psel",    64'(psel),    64'h1);
        check("wr_access_penable", 64'(penable), 64'h1);
        check("wr_access_pwrite",  64'(pwrite),  64'h1);
        check("wr_access_pstrb",   64'(pstrb),   64'hF);
        check("wr_access_cmd_rdy", 64'(cmd_rdy), 64'h0);
        tick();
        check("wr_rsp_vld",  64'(rsp_vld),  64'h1);
        check("wr_rsp_psel", 64'(psel),     64'h0);
        check("wr_rsp_pen",  64'(penable),  64'h0);
        check("wr_rsp_data", 64'(rsp_data), 64'h0);
        check("wr_rsp_cmd_rdy", 64'(cmd_rdy), 64'h0);
        tick();
        check("wr_idle_cmd_rdy", 64'(cmd_rdy), 64'h1);
        check("wr_idle_rsp_vld", 64'(rsp_vld), 64'h0);
        check("wr_idle_busy",    64'(busy),    64'h0);
        check("wr_idle_paddr",   64'(paddr),   64'h10);

        // ---------------- read, 3 wait states ----------------
        pready = 1'b0;
        send(mk_cmd(1'b0, 32'h24, 32'hAAAAAAAA, 4'hF));
        check("rd_pwrite", 64'(pwrite), 64'h0);
        check("rd_pstrb",  64'(pstrb),  64'h0);
        check("rd_paddr",  64'(paddr),  64'h24);
        tick();
        cyc = 0;
        if (penable === 1'b1) cyc++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (penable === 1'b1) cyc++;
        end
        pready = 1'b1;
        prdata = 32'h12345678;
        tick();
        check("rd_penable_cycles", 64'(cyc), 64'd4);
        check("rd_rsp_vld",  64'(rsp_vld),  64'h1);
        check("rd_rsp_data", 64'(rsp_data), 64'h0_1234_5678);
        pready = 1'b0;
        prdata = '0;
        tick();

        // ---------------- write with slverr, then clean read ----------------
        pready  = 1'b1;
        pslverr = 1'b1;
        send(mk_cmd(1'b1, 32'h30, 32'h00000055, 4'h3));
        tick();
        tick();
        check("err_rsp_data", 64'(rsp_data), 64'h1_0000_0000);
        check("err_cnt_1",    64'(err_cnt),  64'd1);
        pslverr = 1'b0;
        tick();
        prdata = 32'hCAFEF00D;
        send(mk_cmd(1'b0, 32'h40, 32'h0, 4'h0));
        tick();
        tick();
        check("clean_rsp_data", 64'(rsp_data), 64'h0_CAFE_F00D);
        check("clean_err_cnt",  64'(err_cnt),  64'd1);
        tick();

        // ---------------- timeout with pready held low ----------------
        pready = 1'b0;
        prdata = 32'hFFFFFFFF;
        send(mk_cmd(1'b0, 32'h44, 32'h0, 4'h0));
        tick();
        cyc = 0;
        while (penable === 1'b1 && cyc < 20) begin
            cyc++;
            tick();
        end
        check("to_access_cycles", 64'(cyc),      64'd8);
        check("to_psel",          64'(psel),     64'h0);
        check("to_rsp_vld",       64'(rsp_vld),  64'h1);
        check("to_rsp_data",      64'(rsp_data), 64'h3_0000_0000);
        check("to_err_cnt",       64'(err_cnt),  64'd2);
        tick();

        // ---------------- pready on ACCESS cycle 8 wins over timeout ----------------
        send(mk_cmd(1'b0, 32'h48, 32'h0, 4'h0));
        tick();
        for (int i = 0; i < 7; i++) tick();
        check("late_penable", 64'(penable), 64'h1);
        pready = 1'b1;
        prdata = 32'h0BADCAFE;
        tick();
        check("late_rsp_vld",  64'(rsp_vld),  64'h1);
        check("late_rsp_data", 64'(rsp_data), 64'h0_0BAD_CAFE);
        check("late_err_cnt",  64'(err_cnt),  64'd2);
        tick();

        // ---------------- response back-pressure with a queued command ----------------
        rsp_rdy = 1'b0;
        pslverr = 1'b1;
        send(mk_cmd(1'b1, 32'h50, 32'h01020304, 4'hF));
        tick();
        tick();
        pslverr = 1'b0;
        check("bp_rsp_data", 64'(rsp_data), 64'h1_0000_0000);
        check("bp_err_cnt",  64'(err_cnt),  64'd3);
        held     = rsp_data;
        cmd_vld  = 1'b1;
        cmd_data = mk_cmd(1'b0, 32'h60, 32'h0, 4'h0);
        prdata   = 32'h11112222;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_data !== held || rsp_vld !== 1'b1 || cmd_rdy !== 1'b0 || psel !== 1'b0) cyc++;
        end
        check("bp_stall_violations", 64'(cyc),   64'd0);
        check("bp_paddr_held",       64'(paddr), 64'h50);
        rsp_rdy = 1'b1;
        tick();
        check("bp_hs_cmd_rdy", 64'(cmd_rdy), 64'h1);
        check("bp_hs_psel",    64'(psel),    64'h0);
        check("bp_hs_paddr",   64'(paddr),   64'h50);
        tick();
        cmd_vld = 1'b0;
        check("bp_next_psel",  64'(psel),  64'h1);
        check("bp_next_paddr", 64'(paddr), 64'h60);
        tick();
        tick();
        check("bp_next_rsp", 64'(rsp_data), 64'h0_1111_2222);
        tick();

        // ---------------- reset in the middle of ACCESS ----------------
        pready = 1'b0;
        send(mk_cmd(1'b0, 32'h70, 32'h0, 4'h0));
        tick();
        check("mid_penable_pre", 64'(penable), 64'h1);
        #2;
        dst_rst = 1'b1;
        #1;
        check("mid_psel",    64'(psel),    64'h0);
        check("mid_penable", 64'(penable), 64'h0);
        check("mid_rsp_vld", 64'(rsp_vld), 64'h0);
        check("mid_err_cnt", 64'(err_cnt), 64'h0);
        check("mid_cmd_rdy", 64'(cmd_rdy), 64'h0);
        tick();
        dst_rst = 1'b0;
        #1;
        check("post_cmd_rdy", 64'(cmd_rdy), 64'h1);
        check("post_paddr",   64'(paddr),   64'h0);
        tick();
        check("post_rsp_vld", 64'(rsp_vld), 64'h0);
        check("post_busy",    64'(busy),    64'h0);
        pready = 1'b1;
        prdata = 32'h87654321;
        send(mk_cmd(1'b0, 32'h80, 32'h0, 4'h0));
        tick();
        tick();
        check("post_rd_rsp_vld",  64'(rsp_vld),  64'h1);
        check("post_rd_rsp_data", 64'(rsp_data), 64'h0_8765_4321);
        tick();
        check("post_rd_idle", 64'(cmd_rdy), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
